// File: rtl/max7219_pkg.sv
// Shared definitions for the MAX7219 receive-side model: register addresses,
// the per-device register struct and the word decoder.
package max7219_pkg;

  localparam logic [3:0] ADDR_NOOP      = 4'h0;
  localparam logic [3:0] ADDR_DIGIT0    = 4'h1;
  localparam logic [3:0] ADDR_DIGIT7    = 4'h8;
  localparam logic [3:0] ADDR_DECODE    = 4'h9;
  localparam logic [3:0] ADDR_INTENSITY = 4'hA;
  localparam logic [3:0] ADDR_SCANLIM   = 4'hB;
  localparam logic [3:0] ADDR_SHUTDOWN  = 4'hC;
  localparam logic [3:0] ADDR_TEST      = 4'hF;

  typedef struct packed {
    logic [7:0][7:0] digit;
    logic [7:0]      decode;
    logic [3:0]      intensity;
    logic [2:0]      scan_limit;
    logic            shutdown_n;
    logic            display_test;
  } max7219_regs_t;

  // Upper nibble of the word is a don't-care; 0xD/0xE fall through as no-ops.
  function automatic max7219_regs_t apply_word(max7219_regs_t r, logic [15:0] w);
    max7219_regs_t n;
    logic [3:0]    addr;
    n    = r;
    addr = w[11:8];
    if (addr >= ADDR_DIGIT0 && addr <= ADDR_DIGIT7)
      n.digit[3'(addr - ADDR_DIGIT0)] = w[7:0];
    else begin
      case (addr)
        ADDR_DECODE:    n.decode       = w[7:0];
        ADDR_INTENSITY: n.intensity    = w[3:0];
        ADDR_SCANLIM:   n.scan_limit   = w[2:0];
        ADDR_SHUTDOWN:  n.shutdown_n   = w[0];
        ADDR_TEST:      n.display_test = w[0];
        default:        n              = r;
      endcase
    end
    return n;
  endfunction

endpackage

// File: rtl/max7219_dev_regs.sv
// Register file of one chained MAX7219: applies its 16-bit word on a latch strobe.
module max7219_dev_regs
  import max7219_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic [15:0]   word,
  input  logic          latch,
  output max7219_regs_t regs
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      regs <= '0;
    else if (latch) regs <= apply_word(regs, word);
  end

endmodule

// File: rtl/max7219_rx.sv
// Receive side of a MAX7219 chain: synchronizes the SPI pins, shifts frames in
// and latches each device word into its register file on a LOAD rise.
module max7219_rx
  import max7219_pkg::*;
#(
  parameter int DEVICES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    spi_din,
  input  logic                    spi_clk,
  input  logic                    spi_load,
  output logic                    spi_dout,
  output logic [64*DEVICES-1:0]   digits,
  output logic [8*DEVICES-1:0]    decode_mode,
  output logic [4*DEVICES-1:0]    intensity,
  output logic [3*DEVICES-1:0]    scan_limit,
  output logic [DEVICES-1:0]      shutdown_n,
  output logic [DEVICES-1:0]      display_test,
  output logic                    frame_done,
  output logic                    frame_err
);

  localparam int         SR_W       = 16 * DEVICES;
  localparam logic [7:0] FRAME_BITS = 8'(SR_W);

  // [0],[1] synchronizer stages, [2] history for edge detection
  logic [2:0] din_s, sclk_s, load_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      din_s  <= '0;
      sclk_s <= '0;
      load_s <= '0;
    end else begin
      din_s  <= {din_s[1:0],  spi_din};
      sclk_s <= {sclk_s[1:0], spi_clk};
      load_s <= {load_s[1:0], spi_load};
    end
  end

  logic clk_rise, load_rise;
  assign clk_rise  = sclk_s[1] & ~sclk_s[2];
  assign load_rise = load_s[1] & ~load_s[2];

  logic [SR_W-1:0] shift_q, shift_nxt;
  logic [7:0]      bit_cnt, cnt_nxt;

  // A load coinciding with a clock rise latches the post-shift contents.
  always_comb begin
    shift_nxt = shift_q;
    cnt_nxt   = bit_cnt;
    if (clk_rise) begin
      shift_nxt = {shift_q[SR_W-2:0], din_s[1]};
      if (bit_cnt != 8'hFF) cnt_nxt = bit_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q    <= '0;
      bit_cnt    <= '0;
      spi_dout   <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      shift_q    <= shift_nxt;
      bit_cnt    <= load_rise ? 8'd0 : cnt_nxt;
      spi_dout   <= shift_nxt[SR_W-1];
      frame_done <= load_rise;
      frame_err  <= load_rise && (cnt_nxt != FRAME_BITS);
    end
  end

  max7219_regs_t regs [DEVICES];

  for (genvar g = 0; g < DEVICES; g++) begin : g_dev
    max7219_dev_regs u_dev (
      .clk   (clk),
      .reset (reset),
      .word  (shift_nxt[g*16 +: 16]),
      .latch (load_rise),
      .regs  (regs[g])
    );

    assign digits[g*64 +: 64]   = regs[g].digit;
    assign decode_mode[g*8 +: 8] = regs[g].decode;
    assign intensity[g*4 +: 4]  = regs[g].intensity;
    assign scan_limit[g*3 +: 3] = regs[g].scan_limit;
    assign shutdown_n[g]        = regs[g].shutdown_n;
    assign display_test[g]      = regs[g].display_test;
  end

endmodule
